// File: rtl/vpu_post_quant.sv
`default_nettype none
// ============================================================================
// Module      : vpu_post_quant
// Description : Per-lane post-processing behind the VPU bias stage. Applies
//               optional ReLU and optional requantization (scale multiply,
//               round-half-up shift, zero-point add, signed saturation) with
//               a fixed three-cycle latency in every mode.
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_post_quant #(
    parameter int VPU_WIDTH      = 16,
    parameter int DATA_WIDTH_IN  = 32,
    parameter int DATA_WIDTH_OUT = 8,
    parameter int SCALE_WIDTH    = 16,
    parameter int SHIFT_WIDTH    = 5
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [2:0]                                   vpu_mode,
    input  logic [SCALE_WIDTH-1:0]                       cfg_scale,
    input  logic [SHIFT_WIDTH-1:0]                       cfg_shift,
    input  logic [DATA_WIDTH_OUT-1:0]                    cfg_zero_point,
    input  logic                                         cfg_load,
    input  logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0]      pq_data_in,
    input  logic [VPU_WIDTH-1:0]                         pq_valid_in,
    input  logic                                         sat_clear,
    output logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0]      pq_data_out,
    output logic [VPU_WIDTH-1:0]                         pq_valid_out,
    output logic                                         busy,
    output logic                                         cfg_err,
    output logic [15:0]                                  sat_count
);

    // Product is wide enough that s1 * scale can never overflow.
    localparam int c_prod_w = DATA_WIDTH_IN + SCALE_WIDTH + 1;
    // One extra bit for the rounding add, one more for the zero-point add.
    localparam int c_sum_w  = c_prod_w + 1;
    localparam int c_q_w    = c_prod_w + 2;

    localparam logic signed [c_q_w-1:0] c_q_max =
        {{(c_q_w-DATA_WIDTH_OUT+1){1'b0}}, {(DATA_WIDTH_OUT-1){1'b1}}};
    localparam logic signed [c_q_w-1:0] c_q_min =
        {{(c_q_w-DATA_WIDTH_OUT+1){1'b1}}, {(DATA_WIDTH_OUT-1){1'b0}}};
    localparam logic signed [DATA_WIDTH_OUT-1:0] c_o_max = {1'b0, {(DATA_WIDTH_OUT-1){1'b1}}};
    localparam logic signed [DATA_WIDTH_OUT-1:0] c_o_min = {1'b1, {(DATA_WIDTH_OUT-1){1'b0}}};

    // Shadow configuration; only changes while the pipeline is empty.
    logic                              r_relu_en;
    logic                              r_quant_en;
    logic [SCALE_WIDTH-1:0]            r_scale;
    logic [SHIFT_WIDTH-1:0]            r_shift;
    logic signed [DATA_WIDTH_OUT-1:0]  r_zp;
    logic                              r_cfg_err;
    logic [15:0]                       r_sat_count;

    logic [VPU_WIDTH-1:0]              w_lane_sat;
    logic [VPU_WIDTH-1:0]              w_lane_busy;
    logic                              w_busy;

    // Mode bit 0 belongs to the upstream bias stage and has no meaning here.
    logic                              w_unused_mode0;
    assign w_unused_mode0 = vpu_mode[0];

    for (genvar l = 0; l < VPU_WIDTH; l++) begin : g_lane
        logic                              r_s1_valid;
        logic                              r_s2_valid;
        logic                              r_s3_valid;
        logic signed [DATA_WIDTH_IN-1:0]   r_s1_data;
        logic signed [c_prod_w-1:0]        r_s2_data;
        logic [DATA_WIDTH_IN-1:0]          r_s3_data;

        logic signed [DATA_WIDTH_IN-1:0]   w_x;
        logic signed [DATA_WIDTH_IN-1:0]   w_relu;
        logic signed [c_prod_w-1:0]        w_a;
        logic signed [c_prod_w-1:0]        w_b;
        logic signed [c_prod_w-1:0]        w_prod;
        logic [c_sum_w-1:0]                w_rnd;
        logic signed [c_sum_w-1:0]         w_sum;
        logic signed [c_sum_w-1:0]         w_r;
        logic signed [c_q_w-1:0]           w_q;
        logic                              w_hi;
        logic                              w_lo;
        logic signed [DATA_WIDTH_OUT-1:0]  w_qc;
        logic [DATA_WIDTH_IN-1:0]          w_out;

        assign w_x    = pq_data_in[l];
        assign w_relu = (r_relu_en && w_x[DATA_WIDTH_IN-1]) ? '0 : w_x;

        // Scale is unsigned, so it is zero-extended before the signed multiply.
        assign w_a    = c_prod_w'(r_s1_data);
        assign w_b    = {{(c_prod_w-SCALE_WIDTH){1'b0}}, r_scale};
        assign w_prod = w_a * w_b;

        // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
        assign w_rnd  = (r_shift == '0) ? '0 : (c_sum_w'(1'b1) << (r_shift - 1'b1));
        assign w_sum  = c_sum_w'(r_s2_data) + w_rnd;
        assign w_r    = w_sum >>> r_shift;
        assign w_q    = c_q_w'(w_r) + c_q_w'(r_zp);
        assign w_hi   = (w_q > c_q_max);
        assign w_lo   = (w_q < c_q_min);
        assign w_qc   = w_hi ? c_o_max : (w_lo ? c_o_min : w_q[DATA_WIDTH_OUT-1:0]);
        assign w_out  = r_quant_en
                      ? {{(DATA_WIDTH_IN-DATA_WIDTH_OUT){w_qc[DATA_WIDTH_OUT-1]}}, w_qc}
                      : r_s2_data[DATA_WIDTH_IN-1:0];

        assign w_lane_sat[l]  = r_quant_en && r_s2_valid && (w_hi || w_lo);
        assign w_lane_busy[l] = r_s1_valid || r_s2_valid || r_s3_valid;
        assign pq_data_out[l] = r_s3_data;
        assign pq_valid_out[l] = r_s3_valid;

        // Three-stage lane pipeline: ReLU, multiply (or pass), requant (or pass).
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
                r_s3_valid <= 1'b0;
                r_s1_data  <= '0;
                r_s2_data  <= '0;
                r_s3_data  <= '0;
            end else begin
                r_s1_valid <= pq_valid_in[l];
                r_s2_valid <= r_s1_valid;
                r_s3_valid <= r_s2_valid;
                r_s1_data  <= w_relu;
                r_s2_data  <= r_quant_en ? w_prod : w_a;
                r_s3_data  <= w_out;
            end
        end
    end

    assign w_busy    = (|pq_valid_in) || (|w_lane_busy);
    assign busy      = w_busy;
    assign cfg_err   = r_cfg_err;
    assign sat_count = r_sat_count;

    // Accept a config load only when nothing is in flight; otherwise flag it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_relu_en  <= 1'b0;
            r_quant_en <= 1'b0;
            r_scale    <= SCALE_WIDTH'(1);
            r_shift    <= '0;
            r_zp       <= '0;
            r_cfg_err  <= 1'b0;
        end else if (cfg_load) begin
            if (w_busy) begin
                r_cfg_err <= 1'b1;
            end else begin
                r_relu_en  <= vpu_mode[1];
                r_quant_en <= vpu_mode[2];
                r_scale    <= cfg_scale;
                r_shift    <= cfg_shift;
                r_zp       <= cfg_zero_point;
            end
        end
    end

    // Saturating count of cycles with any clamped lane; clear wins over count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sat_count <= '0;
        end else if (sat_clear) begin
            r_sat_count <= '0;
        end else if ((|w_lane_sat) && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vpu_post_quant.sv
`default_nettype none
// ============================================================================
// Module      : tb_vpu_post_quant
// Description : Directed self-checking bench for vpu_post_quant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vpu_post_quant;

    localparam int VW   = 16;
    localparam int DIN  = 32;
    localparam int DOUT = 8;
    localparam int SW   = 16;
    localparam int SHW  = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [2:0]              vpu_mode;
    logic [SW-1:0]           cfg_scale;
    logic [SHW-1:0]          cfg_shift;
    logic [DOUT-1:0]         cfg_zero_point;
    logic                    cfg_load;
    logic [VW-1:0][DIN-1:0]  pq_data_in;
    logic [VW-1:0]           pq_valid_in;
    logic                    sat_clear;
    logic [VW-1:0][DIN-1:0]  pq_data_out;
    logic [VW-1:0]           pq_valid_out;
    logic                    busy;
    logic                    cfg_err;
    logic [15:0]             sat_count;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] sc0;

    always #5 clk = ~clk;

    vpu_post_quant #(
        .VPU_WIDTH(VW), .DATA_WIDTH_IN(DIN), .DATA_WIDTH_OUT(DOUT),
        .SCALE_WIDTH(SW), .SHIFT_WIDTH(SHW)
    ) dut (
        .clk(clk), .rst(rst), .vpu_mode(vpu_mode), .cfg_scale(cfg_scale),
        .cfg_shift(cfg_shift), .cfg_zero_point(cfg_zero_point), .cfg_load(cfg_load),
        .pq_data_in(pq_data_in), .pq_valid_in(pq_valid_in), .sat_clear(sat_clear),
        .pq_data_out(pq_data_out), .pq_valid_out(pq_valid_out), .busy(busy),
        .cfg_err(cfg_err), .sat_count(sat_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pq_valid_in = '0;
        pq_data_in  = '0;
        cfg_load    = 1'b0;
        sat_clear   = 1'b0;
    endtask

    task automatic load_cfg(input logic [2:0] m, input logic [15:0] s,
                            input logic [4:0] sh, input logic [7:0] zp);
        vpu_mode = m; cfg_scale = s; cfg_shift = sh; cfg_zero_point = zp;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    // Drives the current pq_data_in for one cycle and steps to the output cycle.
    task automatic send_one(input logic [VW-1:0] mask);
        pq_valid_in = mask;
        step();
        pq_valid_in = '0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        vpu_mode = '0; cfg_scale = '0; cfg_shift = '0; cfg_zero_point = '0;
        idle_inputs();
        step(); step();
        n_cmp++; if (pq_valid_out !== '0) begin n_fail++; $display("FAIL rst_valid: got %h want 0", pq_valid_out); end
        n_cmp++; if (pq_data_out !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", pq_data_out[0]); end
        n_cmp++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL rst_satcnt: got %h want 0", sat_count); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_cfgerr: got %b want 0", cfg_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        idle_inputs();
        pq_data_in[0] = -32'sd5;
        pq_valid_in   = 16'h0001;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pt_busy0: got %b want 1", busy); end
        step();
        pq_valid_in = '0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pt_busy1: got %b want 1", busy); end
        step();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pt_busy2: got %b want 1", busy); end
        n_cmp++; if (pq_valid_out !== 16'h0000) begin n_fail++; $display("FAIL pt_early: got %h want 0000", pq_valid_out); end
        step();
        n_cmp++; if (pq_valid_out !== 16'h0001) begin n_fail++; $display("FAIL pt_valid: got %h want 0001", pq_valid_out); end
        n_cmp++; if (pq_data_out[0] !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL pt_data: got %h want fffffffb", pq_data_out[0]); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pt_busy3: got %b want 1", busy); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pt_busy4: got %b want 0", busy); end
        n_cmp++; if (pq_valid_out !== 16'h0000) begin n_fail++; $display("FAIL pt_late: got %h want 0000", pq_valid_out); end
    endtask

    task automatic test_relu_quant();
        idle_inputs();
        sc0 = sat_count;
        load_cfg(3'b110, 16'd1, 5'd0, 8'd0);
        pq_data_in[0] = -32'sd5;
        pq_data_in[1] = 32'sd300;
        pq_data_in[2] = 32'sd100;
        pq_data_in[3] = -32'sd300;
        send_one(16'h000F);
        n_cmp++; if (pq_valid_out !== 16'h000F) begin n_fail++; $display("FAIL rq_valid: got %h want 000f", pq_valid_out); end
        n_cmp++; if (pq_data_out[0] !== 32'd0) begin n_fail++; $display("FAIL rq_l0: got %h want 0", pq_data_out[0]); end
        n_cmp++; if (pq_data_out[1] !== 32'd127) begin n_fail++; $display("FAIL rq_l1: got %h want 7f", pq_data_out[1]); end
        n_cmp++; if (pq_data_out[2] !== 32'd100) begin n_fail++; $display("FAIL rq_l2: got %h want 64", pq_data_out[2]); end
        n_cmp++; if (pq_data_out[3] !== 32'd0) begin n_fail++; $display("FAIL rq_l3: got %h want 0", pq_data_out[3]); end
        n_cmp++; if (sat_count !== sc0 + 16'd1) begin n_fail++; $display("FAIL rq_satcnt: got %h want %h", sat_count, sc0 + 16'd1); end
        step();
        n_cmp++; if (sat_count !== sc0 + 16'd1) begin n_fail++; $display("FAIL rq_satcnt_hold: got %h want %h", sat_count, sc0 + 16'd1); end
    endtask

    task automatic test_relu_only();
        idle_inputs();
        sc0 = sat_count;
        load_cfg(3'b010, 16'd5, 5'd3, 8'd7);
        pq_data_in[0] = -32'sd7;
        pq_data_in[1] = 32'sd1000;
        pq_data_in[2] = 32'h7FFF_FFFF;
        send_one(16'h0007);
        n_cmp++; if (pq_data_out[0] !== 32'd0) begin n_fail++; $display("FAIL ro_l0: got %h want 0", pq_data_out[0]); end
        n_cmp++; if (pq_data_out[1] !== 32'd1000) begin n_fail++; $display("FAIL ro_l1: got %h want 3e8", pq_data_out[1]); end
        n_cmp++; if (pq_data_out[2] !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL ro_l2: got %h want 7fffffff", pq_data_out[2]); end
        n_cmp++; if (sat_count !== sc0) begin n_fail++; $display("FAIL ro_satcnt: got %h want %h", sat_count, sc0); end
    endtask

    task automatic test_requant();
        idle_inputs();
        step();
        sc0 = sat_count;
        load_cfg(3'b100, 16'd3, 5'd2, 8'hFD);
        pq_data_in[0] = 32'sd10;
        pq_data_in[1] = -32'sd10;
        pq_data_in[2] = -32'sd300;
        pq_data_in[3] = 32'sd70;
        pq_data_in[4] = 32'sd2;
        pq_data_in[5] = -32'sd2;
        send_one(16'h003F);
        n_cmp++; if (pq_valid_out !== 16'h003F) begin n_fail++; $display("FAIL qt_valid: got %h want 003f", pq_valid_out); end
        n_cmp++; if (pq_data_out[0] !== 32'd5) begin n_fail++; $display("FAIL qt_l0: got %h want 5", pq_data_out[0]); end
        n_cmp++; if (pq_data_out[1] !== 32'hFFFF_FFF6) begin n_fail++; $display("FAIL qt_l1: got %h want fffffff6", pq_data_out[1]); end
        n_cmp++; if (pq_data_out[2] !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL qt_l2: got %h want ffffff80", pq_data_out[2]); end
        n_cmp++; if (pq_data_out[3] !== 32'd50) begin n_fail++; $display("FAIL qt_l3: got %h want 32", pq_data_out[3]); end
        n_cmp++; if (pq_data_out[4] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL qt_l4: got %h want ffffffff", pq_data_out[4]); end
        n_cmp++; if (pq_data_out[5] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL qt_l5: got %h want fffffffc", pq_data_out[5]); end
        n_cmp++; if (sat_count !== sc0 + 16'd1) begin n_fail++; $display("FAIL qt_satcnt: got %h want %h", sat_count, sc0 + 16'd1); end
    endtask

    task automatic test_cfg_busy();
        idle_inputs();
        step();
        pq_data_in[0] = 32'sd10;
        pq_valid_in   = 16'h0001;
        step();
        pq_data_in[0] = -32'sd10;
        vpu_mode = 3'b000; cfg_scale = 16'd1; cfg_shift = 5'd0; cfg_zero_point = 8'd0;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        pq_data_in[0] = 32'sd2;
        n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cb_err_set: got %b want 1", cfg_err); end
        step();
        pq_valid_in = '0;
        n_cmp++; if (pq_data_out[0] !== 32'd5 || pq_valid_out[0] !== 1'b1) begin n_fail++; $display("FAIL cb_beat0: got %h/%b want 5/1", pq_data_out[0], pq_valid_out[0]); end
        step();
        n_cmp++; if (pq_data_out[0] !== 32'hFFFF_FFF6) begin n_fail++; $display("FAIL cb_beat1: got %h want fffffff6", pq_data_out[0]); end
        step();
        n_cmp++; if (pq_data_out[0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cb_beat2: got %h want ffffffff", pq_data_out[0]); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cb_drain: got %b want 0", busy); end
        load_cfg(3'b000, 16'd1, 5'd0, 8'd0);
        n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cb_err_sticky: got %b want 1", cfg_err); end
        pq_data_in[0] = -32'sd300;
        send_one(16'h0001);
        n_cmp++; if (pq_data_out[0] !== 32'hFFFF_FED4) begin n_fail++; $display("FAIL cb_newcfg: got %h want fffffed4", pq_data_out[0]); end
    endtask

    task automatic test_sat_count();
        idle_inputs();
        step();
        load_cfg(3'b100, 16'd1, 5'd0, 8'd0);
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;
        n_cmp++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL sc_clear0: got %h want 0", sat_count); end
        pq_data_in[0] = 32'sd1000;
        pq_valid_in   = 16'h0001;
        for (int k = 1; k <= 65539; k++) begin
            step();
            if (k == 100) begin
                n_cmp++; if (sat_count !== 16'd98) begin n_fail++; $display("FAIL sc_k100: got %h want 0062", sat_count); end
            end
            if (k == 65537) begin
                n_cmp++; if (sat_count !== 16'hFFFF) begin n_fail++; $display("FAIL sc_full: got %h want ffff", sat_count); end
            end
        end
        n_cmp++; if (sat_count !== 16'hFFFF) begin n_fail++; $display("FAIL sc_hold: got %h want ffff", sat_count); end
        n_cmp++; if (pq_data_out[0] !== 32'd127) begin n_fail++; $display("FAIL sc_data: got %h want 7f", pq_data_out[0]); end
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;
        n_cmp++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL sc_clear_prio: got %h want 0", sat_count); end
        step();
        n_cmp++; if (sat_count !== 16'd1) begin n_fail++; $display("FAIL sc_after_clear: got %h want 1", sat_count); end
    endtask

    task automatic test_reset_midstream();
        step();
        rst = 1'b0;
        idle_inputs();
        step();
        n_cmp++; if (pq_valid_out !== '0) begin n_fail++; $display("FAIL mr_valid: got %h want 0", pq_valid_out); end
        n_cmp++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL mr_satcnt: got %h want 0", sat_count); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL mr_cfgerr: got %b want 0", cfg_err); end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (pq_valid_out !== '0) begin n_fail++; $display("FAIL mr_drain%0d: got %h want 0", k, pq_valid_out); end
        end
        pq_data_in[0] = -32'sd5;
        pq_data_in[1] = 32'sd300;
        send_one(16'h0003);
        n_cmp++; if (pq_data_out[0] !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL mr_cfg_l0: got %h want fffffffb", pq_data_out[0]); end
        n_cmp++; if (pq_data_out[1] !== 32'd300) begin n_fail++; $display("FAIL mr_cfg_l1: got %h want 12c", pq_data_out[1]); end
        n_cmp++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL mr_nosat: got %h want 0", sat_count); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_relu_quant();
        test_relu_only();
        test_requant();
        test_cfg_busy();
        test_sat_count();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
